sdr_rom_arbiter: RTL and testbench

// - Sits directly downstream of the CPU ROM caches: collects their toggle-handshake 64-bit line fetches and serialises them onto one SDRAM controller read port.
// - Assembles each 4-beat x16 SDRAM burst into a 64-bit line and returns it on the requesting client's data/ack pair.
// - Clients see only the sdr_addr/sdr_req/sdr_ack/sdr_data contract; they are unaware of the arbitration.

---
 rtl/sdr_rom_arbiter_pkg.sv | 19 +
 rtl/sdr_rom_arbiter_picker.sv | 30 +++
 rtl/sdr_rom_arbiter.sv | 128 ++++++++++++
 tb/tb_sdr_rom_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_rom_arbiter_pkg.sv
// Shared constants and types for the SDRAM ROM-cache read arbiter.
package sdr_rom_arbiter_pkg;

  localparam int unsigned SDR_ADDR_W = 27;
  localparam int unsigned SDR_LINE_W = 64;
  localparam int unsigned SDR_BEAT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BURST
  } sdr_arb_state_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdr_rom_arbiter_picker.sv
// rr_picker: combinational rotate-and-find-first over a request vector,
// starting the search at ptr and wrapping modulo N.
module rr_picker
  import sdr_rom_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!any && req_vec[IDX_W'(idx)]) begin
        any       = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sdr_rom_arbiter.sv
// Serialises toggle-handshake 64-bit line fetches from the ROM caches onto one
// SDRAM read port. Define SDR_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module sdr_rom_arbiter
  import sdr_rom_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned BURST_BEATS = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CLIENTS-1:0][SDR_ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS-1:0]                 cli_req,
  output logic [NUM_CLIENTS-1:0]                 cli_ack,
  output logic [NUM_CLIENTS-1:0][SDR_LINE_W-1:0] cli_data,
  output logic [SDR_ADDR_W-1:0]                  ctrl_addr,
  output logic                                   ctrl_req,
  input  logic                                   ctrl_start,
  input  logic [SDR_BEAT_W-1:0]                  ctrl_rdata,
  input  logic                                   ctrl_rvalid,
  output logic                                   busy
);

  localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [SDR_ADDR_W-1:0] LINE_MASK = ~SDR_ADDR_W'(SDR_LINE_W / 8 - 1);

  sdr_arb_state_t state, state_next;

  logic [NUM_CLIENTS-1:0]           pending;
  logic [IDX_W-1:0]                 pick;
  logic                             pick_valid;
  logic [IDX_W-1:0]                 search_ptr;
  logic [IDX_W-1:0]                 grant;
  logic [1:0]                       beat_cnt;
  logic [SDR_LINE_W-SDR_BEAT_W-1:0] line_lo;
  logic                             last_beat;

  assign pending = cli_req ^ cli_ack;

`ifdef SDR_ARB_FIXED_PRIO_EN
  assign search_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  assign search_ptr = rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state == ARB_IDLE && pick_valid) begin
      rr_ptr <= (pick == LAST_IDX) ? '0 : pick + IDX_W'(1);
    end
  end
`endif

  rr_picker #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_vec   (pending),
    .ptr       (search_ptr),
    .grant_idx (pick),
    .any       (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (pick_valid) state_next = ARB_ISSUE;
      ARB_ISSUE: if (ctrl_start) state_next = ARB_BURST;
      ARB_BURST: if (last_beat)  state_next = ARB_IDLE;
      default:                   state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ARB_IDLE);
    last_beat = (state == ARB_BURST) && ctrl_rvalid && (beat_cnt == LAST_BEAT);
  end

  // Beats 0..2 shift in from the top so line_lo ends up as {b2,b1,b0}; the
  // final beat is concatenated directly, equivalent to indexed beat writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cli_ack   <= '0;
      cli_data  <= '0;
      ctrl_addr <= '0;
      ctrl_req  <= 1'b0;
      grant     <= '0;
      beat_cnt  <= '0;
      line_lo   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            ctrl_addr <= cli_addr[pick] & LINE_MASK;
            ctrl_req  <= 1'b1;
          end
        end
        ARB_ISSUE: begin
          if (ctrl_start) begin
            ctrl_req <= 1'b0;
            beat_cnt <= '0;
          end
        end
        ARB_BURST: begin
          if (ctrl_rvalid) begin
            line_lo  <= {ctrl_rdata, line_lo[SDR_LINE_W-SDR_BEAT_W-1:SDR_BEAT_W]};
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == LAST_BEAT) begin
              cli_data[grant] <= {ctrl_rdata, line_lo};
              cli_ack[grant]  <= ~cli_ack[grant];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_rom_arbiter.sv
// Scoreboard bench for sdr_rom_arbiter: directed scenarios plus randomized
// back-to-back traffic checked against a memory/arbitration reference model.
module tb_sdr_rom_arbiter;

  localparam int N = 2;

  typedef struct {
    logic [26:0] addr;
    logic [63:0] line;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0][26:0]   cli_addr;
  logic [N-1:0]         cli_req;
  logic [N-1:0]         cli_ack;
  logic [N-1:0][63:0]   cli_data;
  logic [26:0]          ctrl_addr;
  logic                 ctrl_req;
  logic                 ctrl_start;
  logic [15:0]          ctrl_rdata;
  logic                 ctrl_rvalid;
  logic                 busy;

  logic        d_start = 1'b0, d_rvalid = 1'b0;
  logic [15:0] d_rdata = '0;
  logic        bg_start = 1'b0, bg_rvalid = 1'b0;
  logic [15:0] bg_rdata = '0;
  logic        rnd_on = 1'b0;

  assign ctrl_start  = rnd_on ? bg_start  : d_start;
  assign ctrl_rvalid = rnd_on ? bg_rvalid : d_rvalid;
  assign ctrl_rdata  = rnd_on ? bg_rdata  : d_rdata;

  always #5 clk = ~clk;

  sdr_rom_arbiter #(
    .NUM_CLIENTS (N),
    .BURST_BEATS (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cli_addr    (cli_addr),
    .cli_req     (cli_req),
    .cli_ack     (cli_ack),
    .cli_data    (cli_data),
    .ctrl_addr   (ctrl_addr),
    .ctrl_req    (ctrl_req),
    .ctrl_start  (ctrl_start),
    .ctrl_rdata  (ctrl_rdata),
    .ctrl_rvalid (ctrl_rvalid),
    .busy        (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference SDRAM contents: beat k of the line at address a.
  function automatic logic [15:0] mem_beat(input logic [26:0] a, input int k);
    return 16'((32'(a) >> 3) * 32'h9e37 + 32'(k) * 32'h1234 + 32'h5a5a);
  endfunction

  function automatic logic [63:0] mem_line(input logic [26:0] a);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[16*k +: 16] = mem_beat(a, k);
    return l;
  endfunction

  task automatic serve(input logic [63:0] line, input logic [N-1:0] ack_before);
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d_rvalid = 1'b1;
      d_rdata  = line[16*k +: 16];
      @(negedge clk);
      if (k == 2) check("ack_before_last_beat", 64'(cli_ack), 64'(ack_before));
    end
    d_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cli_req = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard state for the random phase ----------------
  exp_t        expq [N][$];
  logic [N-1:0]       pend = '0;
  logic [N-1:0]       m_prev_ack = '0;
  logic               m_prev_creq = 1'b0;
  logic [N-1:0][63:0] last_data = '0;
  int                 last_g = N - 1;
  int                 cur_g = 0;
  int                 done_cnt = 0;

  always @(posedge clk) begin
    exp_t e;
    int   w, idx, start;
    #1;
    if (rnd_on) begin
      for (int i = 0; i < N; i++) begin
        if (cli_ack[i] !== m_prev_ack[i]) begin
          check("ack_owner", 64'(i), 64'(cur_g));
          check("ack_queue_depth", 64'(expq[i].size()), 64'd1);
          if (expq[i].size() > 0) begin
            e = expq[i].pop_front();
            check("line_data", cli_data[i], e.line);
          end
          check("ack_eq_req", 64'(cli_ack[i]), 64'(cli_req[i]));
          last_data[i] = cli_data[i];
          pend[i]      = 1'b0;
          done_cnt++;
        end else begin
          check("data_hold", cli_data[i], last_data[i]);
        end
      end
      m_prev_ack = cli_ack;
      if (ctrl_req && !m_prev_creq) begin
`ifdef SDR_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (last_g + 1) % N;
`endif
        w = -1;
        for (int k = 0; k < N; k++) begin
          idx = (start + k) % N;
          if (w < 0 && pend[idx]) w = idx;
        end
        check("grant_any", 64'(w >= 0), 64'd1);
        if (w >= 0) begin
          check("grant_addr", 64'(ctrl_addr), 64'(expq[w][0].addr & ~27'h7));
          cur_g  = w;
          last_g = w;
        end
      end
      m_prev_creq = ctrl_req;
    end
  end

  // Background controller model for the random phase.
  always begin
    logic [26:0] a;
    int n, g;
    @(negedge clk);
    if (rnd_on && ctrl_req) begin
      a = ctrl_addr;
      n = int'($urandom % 4);
      for (int j = 0; j < n; j++) begin
        bg_rvalid = 1'($urandom % 2);
        bg_rdata  = 16'($urandom);
        @(negedge clk);
      end
      bg_rvalid = 1'b0;
      bg_start  = 1'b1;
      @(negedge clk);
      bg_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        g = int'($urandom % 3);
        for (int j = 0; j < g; j++) begin
          bg_rvalid = 1'b0;
          @(negedge clk);
        end
        bg_rvalid = 1'b1;
        bg_rdata  = mem_beat(a, k);
        @(negedge clk);
      end
      bg_rvalid = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [26:0] a0, a1, a2, a;
    logic [63:0] l0, l1, l2;
    int   issued, cyc;
    exp_t e;

    reset_n  = 1'b0;
    cli_req  = '0;
    cli_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(cli_ack), 64'd0);
    check("rst_data0", cli_data[0], 64'd0);
    check("rst_ctrl_req", 64'(ctrl_req), 64'd0);
    check("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // Single client, delayed start with stray beats during ISSUE.
    @(negedge clk);
    cli_addr[0] = 27'h100_0007;
    cli_req[0]  = ~cli_req[0];
    @(posedge clk) #1;
    check("t1_ctrl_req", 64'(ctrl_req), 64'd1);
    check("t1_ctrl_addr", 64'(ctrl_addr), 64'h100_0000);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t1_hold_req", 64'(ctrl_req), 64'd1);
      check("t1_hold_addr", 64'(ctrl_addr), 64'h100_0000);
      d_rvalid = (i % 3 == 0);
      d_rdata  = 16'hdead;
    end
    @(negedge clk) d_rvalid = 1'b0;
    serve(64'h4444_3333_2222_1111, 2'b00);
    check("t1_ack", 64'(cli_ack), 64'b01);
    check("t1_data", cli_data[0], 64'h4444_3333_2222_1111);
    check("t1_busy_done", 64'(busy), 64'd0);

    // Two clients pending together from reset.
    do_reset();
    a0 = 27'h012_3458; a1 = 27'h345_6789;
    l0 = mem_line(a0); l1 = mem_line(a1);
    @(negedge clk);
    cli_addr[0] = a0; cli_addr[1] = a1;
    cli_req = 2'b11;
    @(posedge clk) #1;
    check("t2_first_addr", 64'(ctrl_addr), 64'(a0 & ~27'h7));
    serve(l0, 2'b00);
    check("t2_ack_a", 64'(cli_ack), 64'b01);
    check("t2_data0", cli_data[0], l0);
    @(posedge clk) #1;
    check("t2_second_addr", 64'(ctrl_addr), 64'(a1 & ~27'h7));
    serve(l1, 2'b01);
    check("t2_ack_b", 64'(cli_ack), 64'b11);
    check("t2_data1", cli_data[1], l1);
    check("t2_data0_hold", cli_data[0], l0);

    // Client 0 alone, then both: pointer now favours client 1.
    a0 = 27'h7ab_cd10; a1 = 27'h000_1238;
    @(negedge clk);
    cli_addr[0] = a0;
    cli_req[0]  = ~cli_req[0];
    @(posedge clk) #1;
    check("t3_solo_addr", 64'(ctrl_addr), 64'(a0 & ~27'h7));
    serve(mem_line(a0), 2'b11);
    check("t3_solo_data", cli_data[0], mem_line(a0));
    @(negedge clk);
    cli_addr[0] = a1; cli_addr[1] = a0;
    cli_req = ~cli_req;
    @(posedge clk) #1;
`ifdef SDR_ARB_FIXED_PRIO_EN
    check("t3_first_addr", 64'(ctrl_addr), 64'(a1 & ~27'h7));
    serve(mem_line(a1), 2'b10);
    check("t3_first_data", cli_data[0], mem_line(a1));
`else
    check("t3_first_addr", 64'(ctrl_addr), 64'(a0 & ~27'h7));
    serve(mem_line(a0), 2'b10);
    check("t3_first_data", cli_data[1], mem_line(a0));
`endif
    @(posedge clk) #1;
`ifdef SDR_ARB_FIXED_PRIO_EN
    check("t3_second_addr", 64'(ctrl_addr), 64'(a0 & ~27'h7));
    serve(mem_line(a0), 2'b11);
`else
    check("t3_second_addr", 64'(ctrl_addr), 64'(a1 & ~27'h7));
    serve(mem_line(a1), 2'b00);
`endif
    check("t3_ack_final", 64'(cli_ack), 64'(cli_req));

    // Reset after two beats, then clean re-service of the still-high request.
    do_reset();
    a2 = 27'h55a_a5a3; l2 = mem_line(a2);
    @(negedge clk);
    cli_addr[0] = a2;
    cli_req[0]  = 1'b1;
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    d_rvalid = 1'b1; d_rdata = 16'haaaa;
    @(negedge clk) d_rdata = 16'hbbbb;
    @(negedge clk) d_rvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t4_rst_ack", 64'(cli_ack), 64'd0);
    check("t4_rst_ctrl_req", 64'(ctrl_req), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    d_rvalid = 1'b1; d_rdata = 16'hcccc;
    @(negedge clk) d_rdata = 16'hdddd;
    @(negedge clk) d_rvalid = 1'b0;
    check("t4_reissue_req", 64'(ctrl_req), 64'd1);
    check("t4_reissue_addr", 64'(ctrl_addr), 64'(a2 & ~27'h7));
    serve(l2, 2'b00);
    check("t4_ack", 64'(cli_ack), 64'b01);
    check("t4_data", cli_data[0], l2);

    // Randomized back-to-back traffic against the scoreboard.
    do_reset();
    @(negedge clk);
    rnd_on = 1'b1;
    issued = 0;
    cyc    = 0;
    while (issued < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (issued < 100 && !pend[i] && ($urandom % 2 == 0)) begin
          a = 27'($urandom);
          cli_addr[i] = a;
          cli_req[i]  = ~cli_req[i];
          pend[i]     = 1'b1;
          e.addr = a;
          e.line = mem_line(a);
          expq[i].push_back(e);
          issued++;
        end
      end
    end
    cyc = 0;
    while (done_cnt < 100 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rnd_issued", 64'(issued), 64'd100);
    check("rnd_completions", 64'(done_cnt), 64'd100);
    rnd_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
